// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. A packed hex/BCD value is captured into a pending register. It moves
// to the display register only on a frame boundary, so a frame never mixes old
// and new digits. Each digit owns one refresh slot of REFRESH_DIV cycles. The
// first DEAD_CYC cycles of every slot keep all anodes off, which prevents
// ghosting between neighbouring digits. Optional leading-zero suppression
// blanks high-order zero digits.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       packed digits, digit k = value[4k+3:4k], digit 0 rightmost
//   load        one-cycle strobe, captures value into the pending register
//   lzs         leading-zero suppression enable
//   en          scan enable; when low the slot position holds and anodes go off
//   bcd         4-bit code of the current digit, to the segment decoder
//   an          anode enables, active low, at most one bit low
//   digit_idx   index of the digit in the current slot
//   frame_tick  one-cycle pulse on the edge where digit_idx wraps to 0
//   busy        a pending load is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*N_DIGITS-1:0]         value,
  input  logic                          load,
  input  logic                          lzs,
  input  logic                          en,
  output logic [3:0]                    bcd,
  output logic [N_DIGITS-1:0]           an,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
  output logic                          frame_tick,
  output logic                          busy
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // State
  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic [IDX_W-1:0]      idx_q,  idx_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic [3:0]            bcd_q,  bcd_d;
  logic [N_DIGITS-1:0]   an_q,   an_d;
  logic                  tick_q, tick_d;

  // Combinational helpers
  logic                  slot_end;
  logic                  frame_end;
  logic                  in_dead;
  logic                  lead_nz;
  logic [N_DIGITS-1:0]   blank;

  // Slot counter and digit index. Everything downstream works from the
  // next-state values so the registered outputs line up with cnt/digit_idx.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    slot_end  = en && (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Tear-free loading. The display takes the pending value as it stood before
  // this edge, so a load landing on the wrap edge waits for the next frame.
  // That load also keeps busy set.
  always_comb begin
    pend_d = load ? value : pend_q;
    disp_d = (frame_end && busy_q) ? pend_q : disp_q;
    busy_d = load || (busy_q && !frame_end);
    tick_d = frame_end;
  end

  // Dead time at the start of each slot. With DEAD_CYC = 0 the comparison
  // would be constant, so that case is split out.
  generate
    if (DEAD_CYC == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt_d < CNT_W'(DEAD_CYC));
    end
  endgenerate

  // blank[k] is set when digit k and every digit above it are zero. Digit 0 is
  // never blanked, so a value of all zeros still shows a single 0.
  always_comb begin
    lead_nz = 1'b0;
    blank   = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lead_nz  = lead_nz | (|disp_d[4*k +: 4]);
      blank[k] = ~lead_nz;
    end
    blank[0] = 1'b0;
  end

  // Output decode. A suppressed digit still drives its code on bcd; only its
  // anode stays off.
  always_comb begin
    bcd_d = disp_d[{idx_d, 2'b00} +: 4];
    if (!en || in_dead || (lzs && blank[idx_d])) begin
      an_d = '1;
    end else begin
      an_d = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the pending and display registers are reset along with the control
  // state, so a reset drops any queued load and the first frame shows zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      bcd_q  <= 4'h0;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      bcd_q  <= bcd_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign bcd        = bcd_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;

endmodule
